// File: rtl/pa_weight_update.sv
// rtl/pa_weight_update.sv - batched gradient-descent update of adapter weights and biases (flopoco fp16)
// Optional macro PA_GRAD_CLIP_EN clamps oversized scaled gradients before they are applied.

module FPADD_16bit_WRAPPER #(
  parameter int BW = 17
) (
  input  logic [BW:0] a,
  input  logic [BW:0] b,
  output logic [BW:0] r
);
  logic              a_big;
  logic              bs;
  logic [4:0]        be;
  logic [4:0]        se;
  logic [4:0]        d;
  logic [13:0]       bm;
  logic [13:0]       sm;
  logic [13:0]       sm_sh;
  logic [14:0]       sum;
  logic signed [7:0] e_res;
  logic [BW:0]       norm;

  always_comb begin
    a_big = a[BW-3:0] >= b[BW-3:0];
    bs    = a_big ? a[BW-2] : b[BW-2];
    be    = a_big ? a[BW-3:BW-7] : b[BW-3:BW-7];
    se    = a_big ? b[BW-3:BW-7] : a[BW-3:BW-7];
    bm    = {1'b1, (a_big ? a[9:0] : b[9:0]), 3'b000};
    sm    = {1'b1, (a_big ? b[9:0] : a[9:0]), 3'b000};
    d     = be - se;
    sm_sh = (d > 5'd13) ? 14'd0 : (sm >> d);
    if (a[BW-2] == b[BW-2]) sum = {1'b0, bm} + {1'b0, sm_sh};
    else                    sum = {1'b0, bm} - {1'b0, sm_sh};
    e_res = $signed({3'b000, be});
    if (sum[14]) begin
      sum   = sum >> 1;
      e_res = e_res + 8'sd1;
    end
    // Cancellation can leave the leading one anywhere below bit 13.
    for (int i = 0; i < 13; i++) begin
      if (sum != 15'd0 && !sum[13]) begin
        sum   = sum << 1;
        e_res = e_res - 8'sd1;
      end
    end
    if (sum == 15'd0 || e_res < 0) norm = '0;
    else if (e_res > 8'sd31)       norm = {2'b10, bs, 15'd0};
    else                           norm = {2'b01, bs, e_res[4:0], sum[12:3]};

    if (a[BW:BW-1] == 2'b11 || b[BW:BW-1] == 2'b11) r = {2'b11, 16'd0};
    else if (a[BW:BW-1] == 2'b10 && b[BW:BW-1] == 2'b10)
      r = (a[BW-2] == b[BW-2]) ? a : {2'b11, 16'd0};
    else if (a[BW:BW-1] == 2'b10) r = a;
    else if (b[BW:BW-1] == 2'b10) r = b;
    else if (a[BW:BW-1] == 2'b00) r = b;
    else if (b[BW:BW-1] == 2'b00) r = a;
    else                          r = norm;
  end
endmodule

module FPMult_16bit_WRAPPER #(
  parameter int BW = 17
) (
  input  logic [BW:0] a,
  input  logic [BW:0] b,
  output logic [BW:0] r
);
  logic              s;
  logic [21:0]       p;
  logic signed [7:0] e_res;
  logic [9:0]        f;
  logic [BW:0]       norm;
  logic [1:0]        xa;
  logic [1:0]        xb;

  always_comb begin
    xa    = a[BW:BW-1];
    xb    = b[BW:BW-1];
    s     = a[BW-2] ^ b[BW-2];
    p     = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
    e_res = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
    f     = p[19:10];
    if (p[21]) begin
      f     = p[20:11];
      e_res = e_res + 8'sd1;
    end
    if (e_res < 0)          norm = '0;
    else if (e_res > 8'sd31) norm = {2'b10, s, 15'd0};
    else                     norm = {2'b01, s, e_res[4:0], f};

    if (xa == 2'b11 || xb == 2'b11 || (xa == 2'b10 && xb == 2'b00) || (xa == 2'b00 && xb == 2'b10))
      r = {2'b11, 16'd0};
    else if (xa == 2'b10 || xb == 2'b10) r = {2'b10, s, 15'd0};
    else if (xa == 2'b00 || xb == 2'b00) r = '0;
    else                                 r = norm;
  end
endmodule

module pa_weight_update #(
  parameter int         PA_KERNELS = 1,
  parameter int         BATCH_SIZE = 4,
  parameter int         BW         = 17,
  parameter logic [4:0] CLIP_EXP   = 5'd15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_init,
  input  logic [PA_KERNELS-1:0][BW:0]  init_weight,
  input  logic [PA_KERNELS-1:0][BW:0]  init_bias,
  input  logic [BW:0]                  lr,
  input  logic                         grad_valid,
  output logic                         grad_ready,
  input  logic [PA_KERNELS-1:0][BW:0]  bpWchange_PA,
  input  logic [PA_KERNELS-1:0][BW:0]  bpBchange_PA,
  output logic [PA_KERNELS-1:0][BW:0]  weights_PA,
  output logic [PA_KERNELS-1:0][BW:0]  biases_PA,
  output logic                         busy,
  output logic                         update_done,
  output logic [7:0]                   batch_count,
  output logic                         clip_flag
);
  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_SCALE, S_APPLY, S_DONE} state_t;
  localparam logic [7:0] BATCH_LAST = 8'(BATCH_SIZE);

  state_t                      state;
  logic [PA_KERNELS-1:0][BW:0] acc_w, acc_b, scaled_w, scaled_b;
  logic [PA_KERNELS-1:0][BW:0] sum_w, sum_b, prod_w, prod_b, clip_w, clip_b;
  logic [PA_KERNELS-1:0][BW:0] neg_w, neg_b, upd_w, upd_b;
  logic [7:0]                  count_next;
  logic                        accept;

  // Sign flip only for finite/infinite values; zero and NaN pass untouched.
  function automatic logic [BW:0] negate(input logic [BW:0] v);
    logic [BW:0] n;
    n = v;
    if (v[BW] ^ v[BW-1]) n[BW-2] = ~v[BW-2];
    return n;
  endfunction

`ifdef PA_GRAD_CLIP_EN
  logic [PA_KERNELS-1:0] hit_w, hit_b;

  function automatic logic [BW:0] clamp(input logic [BW:0] v);
    if (v[BW:BW-1] == 2'b11) return '0;
    if (v[BW:BW-1] == 2'b10 || (v[BW:BW-1] == 2'b01 && v[BW-3:BW-7] > CLIP_EXP))
      return {2'b01, v[BW-2], CLIP_EXP, 10'd0};
    return v;
  endfunction
`endif

  assign accept     = grad_valid && grad_ready;
  assign count_next = (state == S_IDLE) ? 8'd1 : batch_count + 8'd1;

  for (genvar k = 0; k < PA_KERNELS; k++) begin : g_kernel
    FPADD_16bit_WRAPPER  #(.BW(BW)) u_acc_w (.a(acc_w[k]), .b(bpWchange_PA[k]), .r(sum_w[k]));
    FPADD_16bit_WRAPPER  #(.BW(BW)) u_acc_b (.a(acc_b[k]), .b(bpBchange_PA[k]), .r(sum_b[k]));
    FPMult_16bit_WRAPPER #(.BW(BW)) u_mul_w (.a(lr), .b(acc_w[k]), .r(prod_w[k]));
    FPMult_16bit_WRAPPER #(.BW(BW)) u_mul_b (.a(lr), .b(acc_b[k]), .r(prod_b[k]));
    assign neg_w[k] = negate(scaled_w[k]);
    assign neg_b[k] = negate(scaled_b[k]);
    FPADD_16bit_WRAPPER  #(.BW(BW)) u_app_w (.a(weights_PA[k]), .b(neg_w[k]), .r(upd_w[k]));
    FPADD_16bit_WRAPPER  #(.BW(BW)) u_app_b (.a(biases_PA[k]), .b(neg_b[k]), .r(upd_b[k]));
`ifdef PA_GRAD_CLIP_EN
    assign clip_w[k] = clamp(prod_w[k]);
    assign clip_b[k] = clamp(prod_b[k]);
    assign hit_w[k]  = clip_w[k] != prod_w[k];
    assign hit_b[k]  = clip_b[k] != prod_b[k];
`else
    assign clip_w[k] = prod_w[k];
    assign clip_b[k] = prod_b[k];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      grad_ready  <= 1'b1;
      busy        <= 1'b0;
      update_done <= 1'b0;
      batch_count <= 8'd0;
      weights_PA  <= '0;
      biases_PA   <= '0;
      acc_w       <= '0;
      acc_b       <= '0;
      scaled_w    <= '0;
      scaled_b    <= '0;
    end else begin
      update_done <= 1'b0;
      case (state)
        S_IDLE, S_ACCUM: begin
          if (state == S_IDLE && load_init) begin
            weights_PA <= init_weight;
            biases_PA  <= init_bias;
          end
          if (accept) begin
            acc_w       <= (state == S_IDLE) ? bpWchange_PA : sum_w;
            acc_b       <= (state == S_IDLE) ? bpBchange_PA : sum_b;
            batch_count <= count_next;
            if (count_next == BATCH_LAST) begin
              state      <= S_SCALE;
              grad_ready <= 1'b0;
              busy       <= 1'b1;
            end else begin
              state <= S_ACCUM;
            end
          end
        end
        S_SCALE: begin
          scaled_w <= clip_w;
          scaled_b <= clip_b;
          state    <= S_APPLY;
        end
        S_APPLY: begin
          weights_PA <= upd_w;
          biases_PA  <= upd_b;
          state      <= S_DONE;
        end
        S_DONE: begin
          update_done <= 1'b1;
          batch_count <= 8'd0;
          acc_w       <= '0;
          acc_b       <= '0;
          grad_ready  <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PA_GRAD_CLIP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     clip_flag <= 1'b0;
    else if (state == S_IDLE && load_init)       clip_flag <= 1'b0;
    else if (state == S_SCALE && (|hit_w || |hit_b)) clip_flag <= 1'b1;
  end
`else
  assign clip_flag = 1'b0;
`endif
endmodule

// File: tb/tb_pa_weight_update.sv
// tb/tb_pa_weight_update.sv - real-valued reference model plus directed update scenarios
// Clip expectations follow PA_GRAD_CLIP_EN when it is defined.
module tb_pa_weight_update;
  localparam int K  = 2;
  localparam int BS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_init = 1'b0;
  logic grad_valid = 1'b0;
  logic [K-1:0][17:0] init_w = '0;
  logic [K-1:0][17:0] init_b = '0;
  logic [K-1:0][17:0] gw = '0;
  logic [K-1:0][17:0] gb = '0;
  logic [17:0] lr = 18'h13800;
  logic grad_ready, busy, update_done, clip_flag;
  logic [7:0] batch_count;
  logic [K-1:0][17:0] weights, biases;

  logic load1 = 1'b0;
  logic gv1 = 1'b0;
  logic [0:0][17:0] iw1 = '0;
  logic [0:0][17:0] ib1 = '0;
  logic [0:0][17:0] gw1 = '0;
  logic [0:0][17:0] gb1 = '0;
  logic ready1, busy1, done1, clip1;
  logic [7:0] count1;
  logic [0:0][17:0] w1, b1;

  int checks = 0;
  int errors = 0;

  pa_weight_update #(.PA_KERNELS(K), .BATCH_SIZE(BS)) dut (
    .clk(clk), .rst(rst), .load_init(load_init), .init_weight(init_w), .init_bias(init_b),
    .lr(lr), .grad_valid(grad_valid), .grad_ready(grad_ready),
    .bpWchange_PA(gw), .bpBchange_PA(gb), .weights_PA(weights), .biases_PA(biases),
    .busy(busy), .update_done(update_done), .batch_count(batch_count), .clip_flag(clip_flag));

  pa_weight_update #(.PA_KERNELS(1), .BATCH_SIZE(1)) dut1 (
    .clk(clk), .rst(rst), .load_init(load1), .init_weight(iw1), .init_bias(ib1),
    .lr(lr), .grad_valid(gv1), .grad_ready(ready1),
    .bpWchange_PA(gw1), .bpBchange_PA(gb1), .weights_PA(w1), .biases_PA(b1),
    .busy(busy1), .update_done(done1), .batch_count(count1), .clip_flag(clip1));

  always #5 clk = ~clk;

  function automatic real f2r(input logic [17:0] v);
    real m;
    int e;
    if (v[17:16] == 2'b00) return 0.0;
    m = 1.0 + real'(v[9:0]) / 1024.0;
    e = int'({27'd0, v[14:10]}) - 15;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return v[15] ? -m : m;
  endfunction

  function automatic logic [17:0] r2f(input real x);
    real a;
    int e;
    logic [9:0] f;
    logic [4:0] eb;
    if (x == 0.0) return 18'h00000;
    a = (x < 0.0) ? -x : x;
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    f  = 10'($rtoi((a - 1.0) * 1024.0));
    eb = 5'(e);
    return {2'b01, (x < 0.0), eb, f};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: batch counter, countdown of the three busy cycles, real-valued parameters.
  int  m_cnt = 0;
  int  m_left = 0;
  bit  m_done = 0;
  bit  m_clip = 0;
  real m_w[K], m_b[K], m_aw[K], m_ab[K], m_sw[K], m_sb[K];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_left = 0; m_done = 0; m_clip = 0;
      for (int k = 0; k < K; k++) begin
        m_w[k] = 0.0; m_b[k] = 0.0; m_aw[k] = 0.0; m_ab[k] = 0.0; m_sw[k] = 0.0; m_sb[k] = 0.0;
      end
    end else begin
      m_done = 0;
      if (m_left == 0) begin
        if (load_init && m_cnt == 0) begin
          for (int k = 0; k < K; k++) begin m_w[k] = f2r(init_w[k]); m_b[k] = f2r(init_b[k]); end
          m_clip = 0;
        end
        if (grad_valid) begin
          for (int k = 0; k < K; k++) begin
            m_aw[k] = (m_cnt == 0) ? f2r(gw[k]) : m_aw[k] + f2r(gw[k]);
            m_ab[k] = (m_cnt == 0) ? f2r(gb[k]) : m_ab[k] + f2r(gb[k]);
          end
          m_cnt++;
          if (m_cnt == BS) m_left = 3;
        end
      end else begin
        if (m_left == 3) begin
          for (int k = 0; k < K; k++) begin
            m_sw[k] = f2r(lr) * m_aw[k];
            m_sb[k] = f2r(lr) * m_ab[k];
`ifdef PA_GRAD_CLIP_EN
            if (m_sw[k] >= 2.0 || m_sw[k] <= -2.0) begin m_sw[k] = (m_sw[k] < 0.0) ? -1.0 : 1.0; m_clip = 1; end
            if (m_sb[k] >= 2.0 || m_sb[k] <= -2.0) begin m_sb[k] = (m_sb[k] < 0.0) ? -1.0 : 1.0; m_clip = 1; end
`endif
          end
        end else if (m_left == 2) begin
          for (int k = 0; k < K; k++) begin m_w[k] = m_w[k] - m_sw[k]; m_b[k] = m_b[k] - m_sb[k]; end
        end else begin
          m_done = 1;
          m_cnt  = 0;
        end
        m_left--;
      end
    end
  end

  always @(negedge clk) begin
    chk("grad_ready", {31'd0, grad_ready}, {31'd0, m_left == 0});
    chk("busy", {31'd0, busy}, {31'd0, m_left != 0});
    chk("update_done", {31'd0, update_done}, {31'd0, m_done});
    chk("batch_count", {24'd0, batch_count}, m_cnt);
    chk("clip_flag", {31'd0, clip_flag}, {31'd0, m_clip});
    for (int k = 0; k < K; k++) begin
      chk("weights_model", {14'd0, weights[k]}, {14'd0, r2f(m_w[k])});
      chk("biases_model", {14'd0, biases[k]}, {14'd0, r2f(m_b[k])});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [17:0] w0, input logic [17:0] b0, input logic [17:0] wk1, input logic [17:0] bk1);
    gw[0] = w0; gb[0] = b0; gw[1] = wk1; gb[1] = bk1;
    grad_valid = 1'b1;
    step();
    grad_valid = 1'b0;
  endtask

  logic [17:0] tbl [6] = '{18'h13000, 18'h13400, 18'h13800, 18'h13A00, 18'h13C00, 18'h13600};
  int pulses;
  int run;

  initial begin
    repeat (2) step();
    chk("rst_weights", {14'd0, weights[0]}, 32'h0);
    chk("rst_count", {24'd0, batch_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, grad_ready}, 32'd1);
    chk("rst_done", {31'd0, update_done}, 32'd0);
    rst = 1'b0;
    step();

    // Batch of one on the second instance.
    gv1 = 1'b1; gw1[0] = 18'h13C00; gb1[0] = 18'h00000;
    step();
    gv1 = 1'b0;
    chk("bs1_count_after_accept", {24'd0, count1}, 32'd1);
    chk("bs1_ready_low", {31'd0, ready1}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("bs1_done_timing", {31'd0, done1}, {31'd0, i == 3});
      if (i == 3) chk("bs1_count_cleared", {24'd0, count1}, 32'd0);
    end
    chk("bs1_weight", {14'd0, w1[0]}, 32'h1B800);
    chk("bs1_bias", {14'd0, b1[0]}, 32'h00000);

    // Basic update with two kernels.
    init_w[0] = 18'h13C00; init_b[0] = 18'h00000;
    init_w[1] = 18'h14000; init_b[1] = 18'h13C00;
    load_init = 1'b1;
    step();
    load_init = 1'b0;
    send(18'h13800, 18'h13400, 18'h13400, 18'h13C00);
    send(18'h13800, 18'h13400, 18'h13400, 18'h13C00);
    pulses = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (update_done) pulses++;
      chk("done_pulse_timing", {31'd0, update_done}, {31'd0, i == 3});
    end
    chk("done_pulse_count", pulses, 32'd1);
    chk("w0_half", {14'd0, weights[0]}, 32'h13800);
    chk("b0_neg_quarter", {14'd0, biases[0]}, 32'h1B400);
    chk("w1_1p75", {14'd0, weights[1]}, 32'h13F00);
    chk("b1_zero", {14'd0, biases[1]}, 32'h00000);

    // load_init while busy is ignored; in idle it takes effect.
    send(18'h13800, 18'h13400, 18'h13400, 18'h13C00);
    send(18'h13800, 18'h13400, 18'h13400, 18'h13C00);
    init_w[0] = 18'h15000; init_b[0] = 18'h15000;
    load_init = 1'b1;
    step();
    load_init = 1'b0;
    repeat (3) step();
    chk("busy_load_ignored_w", {14'd0, weights[0]}, 32'h00000);
    chk("busy_load_ignored_b", {14'd0, biases[0]}, 32'h1B800);
    init_w[0] = 18'h13C00; init_b[0] = 18'h00000;
    init_w[1] = 18'h13C00; init_b[1] = 18'h00000;
    load_init = 1'b1;
    step();
    load_init = 1'b0;
    chk("idle_load_w0", {14'd0, weights[0]}, 32'h13C00);
    chk("idle_load_b1", {14'd0, biases[1]}, 32'h00000);

    // Oversized scaled gradient: 1.0 * (2.0 + 2.0).
    lr = 18'h13C00;
    send(18'h14000, 18'h00000, 18'h00000, 18'h00000);
    send(18'h14000, 18'h00000, 18'h00000, 18'h00000);
    repeat (4) step();
`ifdef PA_GRAD_CLIP_EN
    chk("clip_weight", {14'd0, weights[0]}, 32'h00000);
    chk("clip_flag_set", {31'd0, clip_flag}, 32'd1);
`else
    chk("noclip_weight", {14'd0, weights[0]}, 32'h1C200);
    chk("noclip_flag", {31'd0, clip_flag}, 32'd0);
`endif
    lr = 18'h13800;

    // Continuous valid over three batches.
    init_w[0] = 18'h13C00; init_b[0] = 18'h00000;
    init_w[1] = 18'h13C00; init_b[1] = 18'h13800;
    load_init = 1'b1;
    step();
    load_init = 1'b0;
    grad_valid = 1'b1;
    pulses = 0;
    run = 0;
    for (int c = 0; c < 40 && pulses < 3; c++) begin
      gw[0] = tbl[c % 6]; gb[0] = tbl[(c + 2) % 6];
      gw[1] = tbl[(c + 4) % 6]; gb[1] = tbl[(c + 1) % 6];
      step();
      if (update_done) pulses++;
      if (!grad_ready) run++;
      else if (run != 0) begin
        chk("ready_low_run", run, 32'd3);
        run = 0;
      end
    end
    grad_valid = 1'b0;
    chk("batches_done", pulses, 32'd3);

    // Reset mid-batch discards the partial sample.
    send(18'h14000, 18'h14000, 18'h00000, 18'h00000);
    chk("partial_count", {24'd0, batch_count}, 32'd1);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    send(18'h13C00, 18'h13400, 18'h00000, 18'h00000);
    chk("fresh_count_one", {24'd0, batch_count}, 32'd1);
    send(18'h13C00, 18'h13400, 18'h00000, 18'h00000);
    repeat (4) step();
    chk("fresh_weight", {14'd0, weights[0]}, 32'h1BC00);
    chk("fresh_bias", {14'd0, biases[0]}, 32'h1B400);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
